hex_print_tx: RTL and testbench
===============================

// Module: hex_print_tx
// PURPOSE
//   Responder side of the DCP print handshake (req_tx/type_tx/dout_tx -> ack_tx).
//   Converts one request into an outgoing UART byte stream on d_tx/vld_tx/rdy_tx.
//   Two request types: a raw byte, or a 32-bit word as 8 ASCII hex digits plus an optional separator.
//   Sits between the DCP command FSM and the UART TX byte interface.
// PARAMETERS
//   HEX_UPPER  1      1: digits A-F use 0x41-0x46; 0: digits a-f use 0x61-0x66
//   SEP_EN     1      1: append the SEP byte after the 8 hex digits; 0: send no separator
//   SEP        8'h20  separator byte (ASCII space)
// PORTS
//   clk      in   1   system clock; every state change happens on its rising edge
//   rst      in   1   synchronous, active-high reset
//   req_tx   in   1   print request (level); the block samples it only in IDLE
//   type_tx  in   1   0: raw byte dout_tx[7:0]; 1: hex word dout_tx[31:0]
//   dout_tx  in   32  data to print; captured on the cycle the request is accepted
//   ack_tx   out  1   one-cycle pulse: the last byte of the request was accepted downstream
//   d_tx     out  8   outgoing byte
//   vld_tx   out  1   d_tx is valid
//   rdy_tx   in   1   downstream accepts d_tx this cycle when vld_tx&&rdy_tx
// BEHAVIOUR
//   Reset (rst=1 at a clk edge): state=IDLE; ack_tx=0, vld_tx=0, d_tx=8'h00; shift reg and counter cleared.
//   Reset mid-stream: vld_tx drops on the next cycle; the partial message is abandoned; no ack_tx is issued.
//   States: IDLE, SEND, ACK, HOLD.
//   IDLE: vld_tx=0, ack_tx=0.
//     - If req_tx=1 at edge k: latch dout_tx into a 32-bit shift reg and latch type_tx.
//     - Load the byte count N: type 0 gives N=1; type 1 gives N=8+SEP_EN.
//     - Go to SEND. vld_tx=1 with the first byte from cycle k+1 (1-cycle latency).
//   SEND: vld_tx=1.
//     - d_tx is held stable while vld_tx&&!rdy_tx.
//     - On each vld_tx&&rdy_tx: advance to the next byte; shift reg <<= 4 for hex digits.
//     - On the handshake of byte N: go to ACK.
//     - vld_tx is never deasserted between bytes of one request.
//   Byte order: type 0 sends dout_tx[7:0] unmodified.
//     Type 1 sends nibbles [31:28] first down to [3:0] last, then SEP if SEP_EN=1.
//   Hex encode, nibble n: n<10 gives 8'h30+n.
//     n>=10 gives 8'h37+n when HEX_UPPER=1, or 8'h57+n when HEX_UPPER=0 (8-bit arithmetic, no carry out).
//   ACK: ack_tx=1 for exactly this one cycle; vld_tx=0.
//     Next state: IDLE if req_tx=0, else HOLD.
//   HOLD: ack_tx=0; wait until req_tx=0, then go to IDLE.
//     A request still held high is never printed twice.
//   The earliest next acceptance is in the cycle after req_tx is seen low.
//   Input changes while busy:
//     - req_tx/type_tx/dout_tx changes during SEND/ACK/HOLD are ignored; the message is built from the values captured at acceptance.
//     - Backpressure: rdy_tx=0 may last indefinitely; no timeout, no byte is lost or repeated.
//   Throughput: with rdy_tx=1 constantly, a type-1 request (SEP_EN=1) has vld_tx high for 9 cycles.
//     ack_tx is high in the 10th cycle after acceptance.
// TESTING
//   1) Raw byte, rdy_tx=1: req=1,type=0,dout=0x0000_0047.
//      -> d_tx=0x47 for 1 cycle at k+1, ack_tx pulse at k+2, then HOLD until req=0.
//   2) Hex word, HEX_UPPER=1, SEP_EN=1, rdy_tx=1: dout=0x1234_ABCF.
//      -> bytes 31 32 33 34 41 42 43 46 20, then a single ack_tx pulse.
//   3) Backpressure on the word 0xDEAD_BEEF: toggle rdy_tx pseudo-randomly, holding 0 up to 5 cycles.
//      -> d_tx stable while stalled; exactly 9 bytes "DEADBEEF " in order; ack_tx only after byte 9.
//   4) Input changes while busy: change dout_tx to 0xFFFF_FFFF and type_tx to 0 after acceptance of 0x0000_0000, type 1.
//      -> output is "00000000 "; keeping req_tx=1 through ACK yields no second message.
//   5) Reset mid-stream: assert rst while the 4th hex digit is pending.
//      -> next cycle vld_tx=0, ack_tx=0, state IDLE.
//      -> A new request then prints a complete, correct message.
//   6) Back-to-back requests: drop req_tx in the ACK cycle, raise it again next cycle with 0x0000_00FF, type 1.
//      -> accepted from IDLE; output "000000FF ".
//      -> Repeat with SEP_EN=0, HEX_UPPER=0: output "000000ff" with no separator.

Source files
------------

// File: rtl/hex_print_tx.sv
// hex_print_tx: print responder turning a raw byte or a 32-bit word (8 hex digits + optional separator) into a byte stream
module hex_print_tx #(
  parameter bit         HEX_UPPER = 1'b1,
  parameter bit         SEP_EN    = 1'b1,
  parameter logic [7:0] SEP       = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_tx,
  input  logic        type_tx,
  input  logic [31:0] dout_tx,
  output logic        ack_tx,
  output logic [7:0]  d_tx,
  output logic        vld_tx,
  input  logic        rdy_tx
);
  typedef enum logic [1:0] {IDLE, SEND, ACK, HOLD} state_t;
  localparam logic [3:0] CNT_HEX = SEP_EN ? 4'd8 : 4'd7;
  state_t      state_q;
  logic [31:0] sh_q;
  logic [3:0]  cnt_q;
  logic [7:0]  d_q;
  logic        vld_q;
  logic        ack_q;
  logic [7:0]  byte0_d;
  logic [7:0]  byte_nxt_d;
  function automatic logic [7:0] hex(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : (HEX_UPPER ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction
  // cnt_q counts bytes still to send after the one on d_tx; the last one is the separator
  assign byte0_d    = type_tx ? hex(dout_tx[31:28]) : dout_tx[7:0];
  assign byte_nxt_d = (SEP_EN && cnt_q == 4'd1) ? SEP : hex(sh_q[27:24]);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      vld_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_tx) begin
          sh_q    <= dout_tx;
          cnt_q   <= type_tx ? CNT_HEX : 4'd0;
          d_q     <= byte0_d;
          vld_q   <= 1'b1;
          state_q <= SEND;
        end
        SEND: if (rdy_tx) begin
          if (cnt_q == 4'd0) begin
            vld_q   <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            sh_q  <= {sh_q[27:0], 4'h0};
            d_q   <= byte_nxt_d;
          end
        end
        ACK: begin
          ack_q   <= 1'b0;
          state_q <= req_tx ? HOLD : IDLE;
        end
        HOLD: if (!req_tx) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ack_tx = ack_q;
  assign d_tx   = d_q;
  assign vld_tx = vld_q;
endmodule

// File: tb/tb_hex_print_tx.sv
// tb_hex_print_tx: bench for hex_print_tx, default build and a lowercase/no-separator build driven side by side
module tb_hex_print_tx;
  logic        clk = 1'b0;
  logic        rst, req, typ, rdy;
  logic [31:0] dout;
  logic [7:0]  d_o [2];
  logic        vld_o [2];
  logic        ack_o [2];
  int          checks = 0, passes = 0;
  bit          go = 1'b0;
  always #5 clk = ~clk;

  hex_print_tx u0 (
    .clk(clk), .rst(rst), .req_tx(req), .type_tx(typ), .dout_tx(dout),
    .ack_tx(ack_o[0]), .d_tx(d_o[0]), .vld_tx(vld_o[0]), .rdy_tx(rdy)
  );
  hex_print_tx #(.HEX_UPPER(1'b0), .SEP_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .req_tx(req), .type_tx(typ), .dout_tx(dout),
    .ack_tx(ack_o[1]), .d_tx(d_o[1]), .vld_tx(vld_o[1]), .rdy_tx(rdy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected message as text, first byte in the low 8 bits
  function automatic logic [71:0] msg(input bit t, input logic [31:0] v, input bit up, input bit sep);
    logic [71:0] m;
    logic [3:0]  nib;
    m = '0;
    if (!t) m[7:0] = v[7:0];
    else begin
      for (int k = 0; k < 8; k++) begin
        nib = v[28-4*k +: 4];
        m[8*k +: 8] = nib < 4'd10 ? "0" + 8'(nib) : (up ? "A" : "a") + 8'(nib) - 8'd10;
      end
      if (sep) m[71:64] = " ";
    end
    return m;
  endfunction

  logic [71:0] m_msg [2];
  int          m_len [2], m_ptr [2];
  bit          m_busy [2], m_ack [2], m_idle [2];
  logic [7:0]  m_d [2];
  logic [7:0]  log_b [2][512];
  int          log_n [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) log_n[i] <= 0;
      else if (vld_o[i] && rdy && log_n[i] < 512) begin
        log_b[i][log_n[i]] <= d_o[i];
        log_n[i] <= log_n[i] + 1;
      end
      if (rst) begin
        m_busy[i] <= 1'b0;
        m_ack[i]  <= 1'b0;
        m_idle[i] <= 1'b1;
        m_d[i]    <= 8'h00;
      end else if (m_ack[i]) begin
        m_ack[i]  <= 1'b0;
        m_idle[i] <= !req;
      end else if (m_busy[i]) begin
        if (rdy) begin
          if (m_ptr[i] + 1 == m_len[i]) begin
            m_busy[i] <= 1'b0;
            m_ack[i]  <= 1'b1;
          end else begin
            m_ptr[i] <= m_ptr[i] + 1;
            m_d[i]   <= m_msg[i][8*(m_ptr[i]+1) +: 8];
          end
        end
      end else if (!m_idle[i]) begin
        if (!req) m_idle[i] <= 1'b1;
      end else if (req) begin
        m_msg[i]  <= msg(typ, dout, i == 0, i == 0);
        m_d[i]    <= 8'(msg(typ, dout, i == 0, i == 0));
        m_len[i]  <= typ ? (i == 0 ? 9 : 8) : 1;
        m_ptr[i]  <= 0;
        m_busy[i] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("vld_u%0d", i), 32'(vld_o[i]), 32'(m_busy[i]));
        chk($sformatf("ack_u%0d", i), 32'(ack_o[i]), 32'(m_ack[i]));
        if (m_busy[i]) chk($sformatf("d_u%0d", i), 32'(d_o[i]), 32'(m_d[i]));
      end
    end
  end

  task automatic chk_log(input int i, input int s, input string e);
    chk($sformatf("len_u%0d_%s", i, e), 32'(log_n[i] - s), 32'(e.len()));
    if (log_n[i] - s == e.len())
      for (int k = 0; k < e.len(); k++)
        chk($sformatf("byte%0d_u%0d_%s", k, i, e), 32'(log_b[i][s+k]), 32'(e.getc(k)));
  endtask

  // Called right after a negedge; drives one request and waits for ack from u0
  task automatic run(input bit t, input logic [31:0] v, input bit bp, input bit cor,
                     input int hold, output int cyc);
    int stall;
    bit done;
    stall = 0;
    done  = 1'b0;
    cyc   = 0;
    req = 1'b1; typ = t; dout = v;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (cor) begin dout = '1; typ = 1'b0; end
      if (ack_o[0]) begin done = 1'b1; cyc = c + 1; end
      else if (bp) begin
        if (stall > 0) begin rdy = 1'b0; stall--; end
        else begin
          rdy = 1'b1;
          if ($urandom_range(0, 2) == 0) stall = $urandom_range(1, 5);
        end
      end
    end
    chk("ack_seen", 32'(done), 32'd1);
    rdy = 1'b1;
    repeat (hold) @(negedge clk);
    req = 1'b0;
    @(negedge clk);
  endtask

  int s0, s1, cyc;
  initial begin
    rst = 1'b1; req = 1'b0; typ = 1'b0; dout = '0; rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    go = 1'b1;
    chk("rst_d", 32'(d_o[0]), 32'h00);
    chk("rst_vld", 32'(vld_o[0]), 32'd0);
    chk("rst_ack", 32'(ack_o[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    // raw byte: data at k+1, ack at k+2, then held request stays silent
    req = 1'b1; typ = 1'b0; dout = 32'h0000_0047;
    @(negedge clk);
    chk("raw_vld", 32'(vld_o[0]), 32'd1);
    chk("raw_d", 32'(d_o[0]), 32'h47);
    @(negedge clk);
    chk("raw_ack", 32'(ack_o[0]), 32'd1);
    chk("raw_vld_off", 32'(vld_o[0]), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("hold_quiet", 32'(vld_o[0] | ack_o[0]), 32'd0);
    end
    req = 1'b0;
    @(negedge clk);
    chk_log(0, 0, "G");
    chk_log(1, 0, "G");
    // hex word at full throughput
    s0 = log_n[0]; s1 = log_n[1];
    run(1'b1, 32'h1234_ABCF, 1'b0, 1'b0, 0, cyc);
    chk("throughput", 32'(cyc), 32'd10);
    chk_log(0, s0, "1234ABCF ");
    chk_log(1, s1, "1234abcf");
    // backpressure
    s0 = log_n[0]; s1 = log_n[1];
    run(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 0, cyc);
    chk_log(0, s0, "DEADBEEF ");
    chk_log(1, s1, "deadbeef");
    // inputs changing while busy, request held past ACK
    s0 = log_n[0]; s1 = log_n[1];
    run(1'b1, 32'h0000_0000, 1'b0, 1'b1, 3, cyc);
    chk_log(0, s0, "00000000 ");
    chk_log(1, s1, "00000000");
    // reset while the 4th digit is pending
    req = 1'b1; typ = 1'b1; dout = 32'h1357_9BDF;
    repeat (4) @(negedge clk);
    chk("digit4", 32'(d_o[0]), 32'h37);
    rdy = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_vld0", 32'(vld_o[0]), 32'd0);
    chk("mid_rst_vld1", 32'(vld_o[1]), 32'd0);
    chk("mid_rst_ack", 32'(ack_o[0]), 32'd0);
    rst = 1'b0; req = 1'b0; rdy = 1'b1;
    @(negedge clk);
    s0 = log_n[0]; s1 = log_n[1];
    run(1'b1, 32'h1357_9BDF, 1'b0, 1'b0, 0, cyc);
    chk_log(0, s0, "13579BDF ");
    chk_log(1, s1, "13579bdf");
    // back-to-back: request dropped in the ACK cycle and raised again next cycle
    run(1'b0, 32'h0000_0055, 1'b0, 1'b0, 0, cyc);
    s0 = log_n[0]; s1 = log_n[1];
    run(1'b1, 32'h0000_00FF, 1'b0, 1'b0, 0, cyc);
    chk("b2b_latency", 32'(cyc), 32'd10);
    chk_log(0, s0, "000000FF ");
    chk_log(1, s1, "000000ff");
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
